// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: parity modes, FSM states,
// and a parity helper.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;

  // The argument x is the XOR of the data bits. Odd mode inverts it.
  function automatic logic par_bit(input parity_e mode, input logic x);
    return (mode == PAR_ODD) ? ~x : x;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO. Pushes are ignored when full and pops are
// ignored when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             push_ok, pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter. The frame format is set by parameters, and the
// serial line is registered.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 10,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            i_tx_data,
  input  logic                            i_tx_valid,
  output logic                            o_tx_ready,
  output logic                            o_tx_busy,
  output logic                            o_tx_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_level
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_fd
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, head;
  logic                 par_q, par_n, line_q, line_n;
  logic                 pop, fetch, full, empty;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_tx_valid),
    .wdata (i_tx_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (o_fifo_level)
  );

  assign o_tx_ready = ~full;
  assign o_tx_busy  = (state != S_IDLE) | ~empty;
  assign o_tx_data  = line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      par_q  <= 1'b0;
      line_q <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      par_q  <= par_n;
      line_q <= line_n;
    end
  end

  // line_n is the value the line takes on the next bit. It is computed when the
  // current bit's counter expires, so the line changes exactly on bit boundaries.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par_q;
    line_n  = line_q;
    pop     = 1'b0;
    fetch   = 1'b0;
    if (state != S_IDLE && cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          line_n = 1'b1;
          fetch  = ~empty;
        end
        S_START: begin
          state_n = S_DATA;
          cnt_n   = CW'(CLKS_PER_BIT-1);
          idx_n   = '0;
          line_n  = shreg[0];
        end
        S_DATA: begin
          cnt_n = CW'(CLKS_PER_BIT-1);
          if (idx == 4'(DATA_BITS-1)) begin
            idx_n = '0;
            if (PARITY != PAR_NONE) begin
              state_n = S_PARITY;
              line_n  = par_q;
            end else begin
              state_n = S_STOP;
              line_n  = 1'b1;
            end
          end else begin
            idx_n   = idx + 1'b1;
            shreg_n = shreg >> 1;
            line_n  = shreg[1];
          end
        end
        S_PARITY: begin
          state_n = S_STOP;
          cnt_n   = CW'(CLKS_PER_BIT-1);
          idx_n   = '0;
          line_n  = 1'b1;
        end
        S_STOP: begin
          if (idx == 4'(STOP_BITS-1)) begin
            fetch   = ~empty;
            state_n = S_IDLE;
            line_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
            cnt_n = CW'(CLKS_PER_BIT-1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    // Back-to-back frames: the next start bit follows the last stop bit directly.
    if (fetch) begin
      pop     = 1'b1;
      shreg_n = head;
      par_n   = par_bit(PARITY, ^head);
      state_n = S_START;
      cnt_n   = CW'(CLKS_PER_BIT-1);
      line_n  = 1'b0;
    end
  end
endmodule
